// File: rtl/frame_ram_reader.sv
// Streams the RGB888 frame RAM out as RGB565 bytes (high byte first) in linear
// address order over a valid/ready byte stream feeding the ST7789 transmitter.
`timescale 1ns/1ps

module frame_ram_reader #(
   parameter int X_LIMIT = 240,
   parameter int Y_LIMIT = 240,
   localparam int ADDR_W = $clog2(X_LIMIT) + $clog2(Y_LIMIT),
   localparam int PIXEL_LIMIT = X_LIMIT * Y_LIMIT
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              FRAME_REQUEST,
   output logic              BUSY,
   output logic              FRAME_DONE,
   output logic [ADDR_W-1:0] READ_RAM_ADDRESS,
   input  logic [7:0]        READ_RAM_COLOR_R,
   input  logic [7:0]        READ_RAM_COLOR_G,
   input  logic [7:0]        READ_RAM_COLOR_B,
   output logic [7:0]        M_TDATA,
   output logic              M_TVALID,
   input  logic              M_TREADY,
   output logic              M_TLAST
);

   localparam logic [2:0] IDLE_ST    = 3'd0;
   localparam logic [2:0] READ_ST    = 3'd1;
   localparam logic [2:0] LATCH_ST   = 3'd2;
   localparam logic [2:0] SEND_HI_ST = 3'd3;
   localparam logic [2:0] SEND_LO_ST = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXEL_LIMIT - 1);

   logic [2:0]        state;
   logic [ADDR_W-1:0] address;
   logic [7:0]        pixel_lo;
   logic [7:0]        tdata;
   logic              tvalid;
   logic              tlast;
   logic              frame_done;
   logic              unused_color_bits;

   // Colour LSBs that RGB565 truncates away.
   assign unused_color_bits = ^{READ_RAM_COLOR_R[2:0], READ_RAM_COLOR_G[1:0],
                                READ_RAM_COLOR_B[2:0]};

   // The high byte goes straight into the output register at latch time; only
   // the low byte has to be kept in the pixel register until its turn.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE_ST;
         address    <= '0;
         pixel_lo   <= '0;
         tdata      <= '0;
         tvalid     <= 1'b0;
         tlast      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE_ST: begin
               address <= '0;
               if (FRAME_REQUEST) begin
                  state <= READ_ST;
               end
            end
            READ_ST: begin
               state <= LATCH_ST;
            end
            LATCH_ST: begin
               pixel_lo <= {READ_RAM_COLOR_G[4:2], READ_RAM_COLOR_B[7:3]};
               tdata    <= {READ_RAM_COLOR_R[7:3], READ_RAM_COLOR_G[7:5]};
               tvalid   <= 1'b1;
               tlast    <= 1'b0;
               state    <= SEND_HI_ST;
            end
            SEND_HI_ST: begin
               if (M_TREADY) begin
                  tdata <= pixel_lo;
                  tlast <= (address == LAST_ADDR);
                  state <= SEND_LO_ST;
               end
            end
            SEND_LO_ST: begin
               if (M_TREADY) begin
                  tvalid <= 1'b0;
                  tlast  <= 1'b0;
                  if (address == LAST_ADDR) begin
                     address    <= '0;
                     frame_done <= 1'b1;
                     state      <= IDLE_ST;
                  end else begin
                     address <= address + 1'b1;
                     state   <= READ_ST;
                  end
               end
            end
            default: begin
               state <= IDLE_ST;
            end
         endcase
      end
   end

   assign BUSY             = (state != IDLE_ST);
   assign FRAME_DONE       = frame_done;
   assign READ_RAM_ADDRESS = address;
   assign M_TDATA          = tdata;
   assign M_TVALID         = tvalid;
   assign M_TLAST          = tlast;

endmodule

// File: tb/tb_frame_ram_reader.sv
// Self-checking bench for frame_ram_reader on a 4x2 frame with a registered-read RAM
// model; a negedge monitor pops a scoreboard of expected {TLAST, TDATA} per handshake.
`timescale 1ns/1ps

module tb_frame_ram_reader;

   localparam int X = 4;
   localparam int Y = 2;
   localparam int P = X * Y;
   localparam int AW = 3;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          FRAME_REQUEST;
   logic          BUSY;
   logic          FRAME_DONE;
   logic [AW-1:0] READ_RAM_ADDRESS;
   logic [7:0]    ram_r, ram_g, ram_b;
   logic [7:0]    M_TDATA;
   logic          M_TVALID;
   logic          M_TREADY;
   logic          M_TLAST;

   logic [23:0]   ram [0:P-1];
   logic [8:0]    exp_q [$];
   int            n_compared = 0;
   int            n_mismatched = 0;
   int            byte_count = 0;
   int            stall_count = 0;
   bit            ready_random = 1'b0;
   bit            prev_stall = 1'b0;
   logic [7:0]    prev_data;
   logic          prev_last;
   logic [8:0]    exp_e;

   frame_ram_reader #(.X_LIMIT(X), .Y_LIMIT(Y)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .FRAME_REQUEST(FRAME_REQUEST),
      .BUSY(BUSY),
      .FRAME_DONE(FRAME_DONE),
      .READ_RAM_ADDRESS(READ_RAM_ADDRESS),
      .READ_RAM_COLOR_R(ram_r),
      .READ_RAM_COLOR_G(ram_g),
      .READ_RAM_COLOR_B(ram_b),
      .M_TDATA(M_TDATA),
      .M_TVALID(M_TVALID),
      .M_TREADY(M_TREADY),
      .M_TLAST(M_TLAST)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) {ram_r, ram_g, ram_b} <= ram[READ_RAM_ADDRESS];

   function automatic void fill_pattern();
      for (int i = 0; i < P; i++) ram[i] = (i % 2 == 0) ? 24'hF8FCF8 : 24'h000000;
   endfunction

   function automatic void push_frame(input int first);
      logic [23:0] px;
      logic [15:0] w;
      for (int i = first; i < P; i++) begin
         px = ram[i];
         w  = {px[23:19], px[15:10], px[7:3]};
         exp_q.push_back({1'b0, w[15:8]});
         exp_q.push_back({(i == P - 1), w[7:0]});
      end
   endfunction

   task automatic start_frame();
      @(negedge CLK);
      FRAME_REQUEST = 1'b1;
      @(negedge CLK);
      FRAME_REQUEST = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 1;
      while (FRAME_DONE !== 1'b1 && cyc < budget) begin
         @(negedge CLK);
         cyc++;
      end
   endtask

   initial begin
      M_TREADY = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         M_TREADY = ready_random ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // Byte monitor: a handshake seen here completes on the following posedge.
   initial begin
      forever begin
         @(negedge CLK);
         if (RESET === 1'b1) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               n_compared++;
               if (M_TVALID !== 1'b1 || M_TDATA !== prev_data || M_TLAST !== prev_last) begin
                  n_mismatched++;
                  $display("[TB] FAIL stall_hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                           M_TVALID, M_TDATA, M_TLAST, prev_data, prev_last);
               end
            end
            if (M_TVALID === 1'b1 && M_TREADY === 1'b1) begin
               byte_count++;
               n_compared++;
               if (exp_q.size() == 0) begin
                  n_mismatched++;
                  $display("[TB] FAIL scoreboard_underflow: got data=%h last=%b, need no byte", M_TDATA, M_TLAST);
               end else begin
                  exp_e = exp_q.pop_front();
                  if ({M_TLAST, M_TDATA} !== exp_e) begin
                     n_mismatched++;
                     $display("[TB] FAIL stream_byte: got last=%b data=%h, need last=%b data=%h",
                              M_TLAST, M_TDATA, exp_e[8], exp_e[7:0]);
                  end
               end
            end
            prev_stall = (M_TVALID === 1'b1 && M_TREADY !== 1'b1);
            if (prev_stall) stall_count++;
            prev_data = M_TDATA;
            prev_last = M_TLAST;
         end
      end
   end

   task automatic test_reset();
      RESET = 1'b1;
      FRAME_REQUEST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         n_compared++;
         if ({BUSY, FRAME_DONE, READ_RAM_ADDRESS, M_TDATA, M_TVALID, M_TLAST} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b addr=%0d data=%h valid=%b last=%b, need all 0",
                     BUSY, FRAME_DONE, READ_RAM_ADDRESS, M_TDATA, M_TVALID, M_TLAST);
         end
      end
      RESET = 1'b0;
      FRAME_REQUEST = 1'b0;
      @(negedge CLK);
      n_compared++;
      if (BUSY !== 1'b0 || READ_RAM_ADDRESS !== '0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_release_idle: got busy=%b addr=%0d, need busy=0 addr=0", BUSY, READ_RAM_ADDRESS);
      end
   endtask

   task automatic test_frame();
      int cyc;
      int first_v;
      fill_pattern();
      byte_count = 0;
      push_frame(0);
      start_frame();
      n_compared++;
      if (BUSY !== 1'b1 || READ_RAM_ADDRESS !== '0 || M_TVALID !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL frame_start: got busy=%b addr=%0d valid=%b, need busy=1 addr=0 valid=0",
                  BUSY, READ_RAM_ADDRESS, M_TVALID);
      end
      cyc = 1;
      first_v = 0;
      while (FRAME_DONE !== 1'b1 && cyc < 200) begin
         if (M_TVALID === 1'b1 && first_v == 0) first_v = cyc;
         @(negedge CLK);
         cyc++;
      end
      n_compared++;
      if (first_v != 3) begin
         n_mismatched++;
         $display("[TB] FAIL first_valid_cycle: got %0d, need 3", first_v);
      end
      n_compared++;
      if (cyc != 4 * P + 1 || BUSY !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL frame_done_cycle: got cycle=%0d busy=%b, need cycle=%0d busy=0", cyc, BUSY, 4 * P + 1);
      end
      n_compared++;
      if (byte_count != 2 * P || exp_q.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL frame_byte_count: got %0d left=%0d, need %0d left=0", byte_count, exp_q.size(), 2 * P);
      end
      @(negedge CLK);
      n_compared++;
      if (FRAME_DONE !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL done_pulse_width: got done=%b, need 0", FRAME_DONE);
      end
   endtask

   task automatic test_bit_mapping();
      int cyc;
      fill_pattern();
      ram[0] = 24'hA53C81;
      exp_q.push_back({1'b0, 8'hA1});
      exp_q.push_back({1'b0, 8'hF0});
      push_frame(1);
      start_frame();
      wait_done(200, cyc);
      n_compared++;
      if (cyc != 4 * P + 1 || exp_q.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL bit_mapping_frame: got cycle=%0d left=%0d, need cycle=%0d left=0", cyc, exp_q.size(), 4 * P + 1);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      fill_pattern();
      byte_count = 0;
      stall_count = 0;
      ready_random = 1'b1;
      push_frame(0);
      start_frame();
      wait_done(600, cyc);
      ready_random = 1'b0;
      n_compared++;
      if (cyc != 4 * P + 1 + stall_count) begin
         n_mismatched++;
         $display("[TB] FAIL backpressure_length: got cycle=%0d, need %0d (stalls=%0d)", cyc, 4 * P + 1 + stall_count, stall_count);
      end
      n_compared++;
      if (byte_count != 2 * P || exp_q.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL backpressure_bytes: got %0d left=%0d, need %0d left=0", byte_count, exp_q.size(), 2 * P);
      end
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_back_to_back();
      int cyc;
      fill_pattern();
      push_frame(0);
      start_frame();
      cyc = 1;
      while (FRAME_DONE !== 1'b1 && cyc < 200) begin
         @(negedge CLK);
         cyc++;
         FRAME_REQUEST = (cyc == 10);
      end
      FRAME_REQUEST = 1'b0;
      n_compared++;
      if (cyc != 4 * P + 1 || BUSY !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL midframe_request_ignored: got cycle=%0d busy=%b, need cycle=%0d busy=0", cyc, BUSY, 4 * P + 1);
      end
      FRAME_REQUEST = 1'b1;
      push_frame(0);
      @(negedge CLK);
      FRAME_REQUEST = 1'b0;
      n_compared++;
      if (BUSY !== 1'b1 || READ_RAM_ADDRESS !== '0 || FRAME_DONE !== 1'b0) begin
         n_mismatched++;
         $display("[TB] FAIL back_to_back_start: got busy=%b addr=%0d done=%b, need busy=1 addr=0 done=0",
                  BUSY, READ_RAM_ADDRESS, FRAME_DONE);
      end
      wait_done(200, cyc);
      n_compared++;
      if (cyc != 4 * P + 1 || exp_q.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL back_to_back_frame: got cycle=%0d left=%0d, need cycle=%0d left=0", cyc, exp_q.size(), 4 * P + 1);
      end
   endtask

   task automatic test_reset_mid_frame();
      int cyc;
      fill_pattern();
      push_frame(0);
      start_frame();
      for (cyc = 1; cyc < 16; cyc++) @(negedge CLK);
      n_compared++;
      if (READ_RAM_ADDRESS !== AW'(3) || M_TVALID !== 1'b1) begin
         n_mismatched++;
         $display("[TB] FAIL pre_reset_state: got addr=%0d valid=%b, need addr=3 valid=1", READ_RAM_ADDRESS, M_TVALID);
      end
      #1 RESET = 1'b1;
      @(negedge CLK);
      n_compared++;
      if (exp_q.size() != 2 * P - 8) begin
         n_mismatched++;
         $display("[TB] FAIL pre_reset_bytes: got left=%0d, need %0d", exp_q.size(), 2 * P - 8);
      end
      exp_q.delete();
      n_compared++;
      if ({BUSY, FRAME_DONE, READ_RAM_ADDRESS, M_TDATA, M_TVALID, M_TLAST} !== '0) begin
         n_mismatched++;
         $display("[TB] FAIL midframe_reset: got busy=%b done=%b addr=%0d data=%h valid=%b last=%b, need all 0",
                  BUSY, FRAME_DONE, READ_RAM_ADDRESS, M_TDATA, M_TVALID, M_TLAST);
      end
      #1 RESET = 1'b0;
      byte_count = 0;
      push_frame(0);
      start_frame();
      wait_done(200, cyc);
      n_compared++;
      if (cyc != 4 * P + 1 || byte_count != 2 * P || exp_q.size() != 0) begin
         n_mismatched++;
         $display("[TB] FAIL post_reset_frame: got cycle=%0d bytes=%0d left=%0d, need cycle=%0d bytes=%0d left=0",
                  cyc, byte_count, exp_q.size(), 4 * P + 1, 2 * P);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, need completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      RESET = 1'b1;
      FRAME_REQUEST = 1'b0;
      fill_pattern();
      test_reset();
      test_frame();
      test_bit_mapping();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      repeat (2) @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
